// File: rtl/bus_arbiter.sv
// Two-master (instruction fetch / data memory) arbiter onto a single-ported RAM.
// It has one outstanding access, MEM-first priority with an IF anti-starvation streak, and a response timeout.
module bus_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int MAX_MEM_STREAK = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_wmask,
  output logic              mem_gnt,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] ram_wmask,
  input  logic              ram_ready,
  input  logic              ram_rvalid,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              bus_err,
  output logic              core_lock
);

  typedef enum logic [2:0] {IDLE, IF_REQ, IF_WAIT, MEM_REQ, MEM_WAIT} state_e;

  localparam logic [2:0] MAX_STREAK_C = 3'(MAX_MEM_STREAK);
  localparam logic [7:0] TIMEOUT_C    = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic [2:0]        streak_q, streak_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] wmask_q, wmask_d;
  logic              if_valid_q, if_valid_d;
  logic              mem_valid_q, mem_valid_d;
  logic              bus_err_q, bus_err_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_gnt_c, mem_gnt_c;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    wait_cnt_d  = wait_cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    bus_err_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_gnt_c    = 1'b0;
    mem_gnt_c   = 1'b0;
    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        // MEM wins unless it has already starved a waiting fetch for the full streak
        if (mem_req && !(if_req && streak_q == MAX_STREAK_C)) begin
          mem_gnt_c = 1'b1;
          addr_d    = mem_addr;
          we_d      = mem_we;
          wdata_d   = mem_wdata;
          wmask_d   = mem_wmask;
          state_d   = MEM_REQ;
          if (!if_req)                         streak_d = '0;
          else if (streak_q != MAX_STREAK_C)   streak_d = streak_q + 3'd1;
        end else if (if_req) begin
          if_gnt_c = 1'b1;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          wmask_d  = '0;
          streak_d = '0;
          state_d  = IF_REQ;
        end
      end
      IF_REQ, MEM_REQ: begin
        wait_cnt_d = '0;
        if (ram_ready) state_d = (state_q == IF_REQ) ? IF_WAIT : MEM_WAIT;
      end
      IF_WAIT: begin
        if (ram_rvalid) begin
          if_valid_d = 1'b1;
          if_rdata_d = addr_q[2] ? ram_rdata[63:32] : ram_rdata[31:0];
          state_d    = IDLE;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          if_valid_d = 1'b1;
          bus_err_d  = 1'b1;
          if_rdata_d = '0;
          state_d    = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      MEM_WAIT: begin
        if (ram_rvalid) begin
          mem_valid_d = 1'b1;
          mem_rdata_d = we_q ? '0 : ram_rdata;
          state_d     = IDLE;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          mem_valid_d = 1'b1;
          bus_err_d   = 1'b1;
          mem_rdata_d = '0;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      bus_err_q   <= bus_err_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Combinational outputs are masked while reset is held so everything reads 0
  assign if_gnt    = if_gnt_c & rst;
  assign mem_gnt   = mem_gnt_c & rst;
  assign if_valid  = if_valid_q;
  assign mem_valid = mem_valid_q;
  assign bus_err   = bus_err_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_req   = (state_q == IF_REQ) || (state_q == MEM_REQ);
  assign ram_we    = (state_q == MEM_REQ) & we_q;
  assign ram_addr  = ram_req ? addr_q  : '0;
  assign ram_wdata = ram_req ? wdata_q : '0;
  assign ram_wmask = ram_req ? wmask_q : '0;
  assign core_lock = rst & ~mem_valid_q &
                     ((state_q == MEM_REQ) | (state_q == MEM_WAIT) | (mem_req & ~mem_gnt_c));

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_bus_arbiter;
  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int MAXS = 4;
  localparam int TMO  = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, mem_req, mem_we, ram_ready, ram_rvalid;
  logic [AW-1:0] if_addr, mem_addr;
  logic [DW-1:0] mem_wdata, mem_wmask, ram_rdata;
  logic          if_gnt, if_valid, mem_gnt, mem_valid, ram_req, ram_we, bus_err, core_lock;
  logic [31:0]   if_rdata;
  logic [DW-1:0] mem_rdata, ram_wdata, ram_wmask;
  logic [AW-1:0] ram_addr;

  int total = 0;
  int bad   = 0;

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_MEM_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wmask(ram_wmask), .ram_ready(ram_ready), .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata),
    .bus_err(bus_err), .core_lock(core_lock)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, whether the RAM took the request, how long we waited
  int          m_owner;   // 0 none, 1 fetch, 2 memory
  bit          m_acc;
  int          m_waited;
  int          m_run;
  logic [63:0] m_addr, m_wdata, m_wmask;
  bit          m_we;
  bit          m_ifv, m_memv, m_err;
  logic [31:0] m_ifd;
  logic [63:0] m_memd;
  bit          p_if_gnt, p_mem_gnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_acc = 0; m_waited = 0; m_run = 0;
    m_addr = '0; m_wdata = '0; m_wmask = '0; m_we = 0;
    m_ifv = 0; m_memv = 0; m_err = 0; m_ifd = '0; m_memd = '0;
  endtask

  task automatic predict();
    p_mem_gnt = rst && m_owner == 0 && mem_req && !(if_req && m_run == MAXS);
    p_if_gnt  = rst && m_owner == 0 && if_req && !p_mem_gnt;
  endtask

  task automatic compare_all();
    bit rq;
    predict();
    rq = (m_owner != 0) && !m_acc;
    check("if_gnt",    if_gnt,    p_if_gnt);
    check("mem_gnt",   mem_gnt,   p_mem_gnt);
    check("if_valid",  if_valid,  m_ifv);
    check("if_rdata",  if_rdata,  m_ifd);
    check("mem_valid", mem_valid, m_memv);
    check("mem_rdata", mem_rdata, m_memd);
    check("bus_err",   bus_err,   m_err);
    check("ram_req",   ram_req,   rq);
    check("ram_we",    ram_we,    rq && m_owner == 2 && m_we);
    check("ram_addr",  ram_addr,  rq ? m_addr  : 64'd0);
    check("ram_wdata", ram_wdata, rq ? m_wdata : 64'd0);
    check("ram_wmask", ram_wmask, rq ? m_wmask : 64'd0);
    check("core_lock", core_lock, rst && !m_memv && (m_owner == 2 || (mem_req && !p_mem_gnt)));
  endtask

  task automatic model_step();
    bit nifv, nmemv, nerr, to;
    nifv = 0; nmemv = 0; nerr = 0;
    if (!rst) begin
      model_reset();
      return;
    end
    predict();
    if (m_owner == 0) begin
      if (p_mem_gnt) begin
        m_owner = 2; m_acc = 0;
        m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata; m_wmask = mem_wmask;
        m_run = if_req ? ((m_run < MAXS) ? m_run + 1 : MAXS) : 0;
      end else if (p_if_gnt) begin
        m_owner = 1; m_acc = 0;
        m_addr = if_addr; m_we = 0; m_wdata = '0; m_wmask = '0;
        m_run = 0;
      end
    end else if (!m_acc) begin
      if (ram_ready) begin m_acc = 1; m_waited = 0; end
    end else if (ram_rvalid || m_waited == TMO) begin
      to = !ram_rvalid;
      if (m_owner == 1) begin
        nifv = 1;
        m_ifd = to ? 32'd0 : (m_addr[2] ? ram_rdata[63:32] : ram_rdata[31:0]);
      end else begin
        nmemv = 1;
        m_memd = (to || m_we) ? 64'd0 : ram_rdata;
      end
      nerr = to;
      m_owner = 0;
    end else begin
      m_waited++;
    end
    m_ifv = nifv; m_memv = nmemv; m_err = nerr;
  endtask

  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_addr = '0;
    mem_wdata = '0; mem_wmask = '0; ram_ready = 0; ram_rvalid = 0; ram_rdata = '0;
  endtask

  initial begin
    int n;
    int gq[$];
    logic [63:0] st_addr, st_data;
    rst = 0;
    idle_inputs();
    model_reset();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_ram_req", ram_req, 1'b0);
    check("rst_valid",   {if_valid, mem_valid, bus_err}, 3'b000);
    tick();
    rst = 1;

    // Fetch, minimum latency, upper word select
    if_req = 1; if_addr = 64'h8000_0004;
    #1; check("ifl_gnt", if_gnt, 1'b1);
    tick();
    if_req = 0; ram_ready = 1;
    #1; check("ifl_ram_addr", ram_addr, 64'h8000_0004);
    tick();
    ram_ready = 0; ram_rvalid = 1; ram_rdata = 64'h1111_2222_3333_4444;
    tick();
    ram_rvalid = 0;
    #1; check("ifl_valid", if_valid, 1'b1); check("ifl_rdata", if_rdata, 32'h1111_2222);
    tick();

    // Both requesting: four MEM grants, one IF grant, then MEM again
    if_req = 1; if_addr = 64'h10; mem_req = 1; mem_we = 0; mem_addr = 64'h200;
    ram_ready = 1; ram_rvalid = 1; ram_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    for (int i = 0; i < 18; i++) begin
      #1;
      if (mem_gnt) gq.push_back(1);
      else if (if_gnt) gq.push_back(2);
      tick();
    end
    if_req = 0; mem_req = 0; ram_ready = 0; ram_rvalid = 0;
    tick();
    check("fair_count", gq.size(), 6);
    for (int i = 0; i < 6 && i < gq.size(); i++)
      check("fair_order", gq[i], (i == 4) ? 2 : 1);

    // Load that never gets a response
    mem_req = 1; mem_we = 0; mem_addr = 64'h300;
    #1; check("to_gnt", mem_gnt, 1'b1);
    tick();
    mem_req = 0; ram_ready = 1;
    tick();
    ram_ready = 0;
    n = 0;
    while (n < 400) begin
      #1;
      if (mem_valid === 1'b1) break;
      tick();
      n++;
    end
    check("to_cycles", n, 256);
    check("to_err", bus_err, 1'b1);
    check("to_rdata", mem_rdata, 64'd0);
    if_req = 1; if_addr = 64'h40;
    #1; check("to_idle_gnt", if_gnt, 1'b1);
    tick();
    if_req = 0; ram_ready = 1;
    tick();
    ram_ready = 0; ram_rvalid = 1; ram_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    ram_rvalid = 0;
    #1; check("to_err_clear", bus_err, 1'b0); check("to_next_rdata", if_rdata, 32'h89AB_CDEF);
    tick();

    // Store with a stalled RAM
    st_addr = 64'h0000_1234_5678_9AB8; st_data = 64'hA5A5_5A5A_0F0F_F0F0;
    mem_req = 1; mem_we = 1; mem_addr = st_addr; mem_wdata = st_data; mem_wmask = 64'hFF;
    #1; check("st_gnt", mem_gnt, 1'b1);
    tick();
    mem_req = 0; mem_addr = '1; mem_wdata = '0; mem_wmask = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("st_ram_req", ram_req, 1'b1);
      check("st_ram_we", ram_we, 1'b1);
      check("st_ram_addr", ram_addr, st_addr);
      check("st_ram_wdata", ram_wdata, st_data);
      check("st_ram_wmask", ram_wmask, 64'hFF);
      check("st_lock", core_lock, 1'b1);
      tick();
    end
    ram_ready = 1;
    tick();
    ram_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1; check("st_wait_req", ram_req, 1'b0); check("st_wait_lock", core_lock, 1'b1);
      tick();
    end
    ram_rvalid = 1; ram_rdata = 64'hFFFF_0000_FFFF_0000;
    tick();
    ram_rvalid = 0;
    #1;
    check("st_valid", mem_valid, 1'b1);
    check("st_rdata", mem_rdata, 64'd0);
    check("st_lock_done", core_lock, 1'b0);
    tick();

    // Reset in the middle of a fetch
    if_req = 1; if_addr = 64'h1000;
    tick();
    if_req = 0; ram_ready = 1;
    tick();
    ram_ready = 0; rst = 0;
    tick();
    rst = 1; ram_rvalid = 1; ram_rdata = 64'h7777_6666_5555_4444;
    #1;
    check("mr_if_valid", if_valid, 1'b0);
    check("mr_if_rdata", if_rdata, 32'd0);
    check("mr_ram_req", ram_req, 1'b0);
    check("mr_err", bus_err, 1'b0);
    tick();
    ram_rvalid = 0;
    #1; check("mr_if_valid2", if_valid, 1'b0);
    tick();
    if_req = 1; if_addr = 64'h2000;
    #1; check("mr_gnt", if_gnt, 1'b1);
    tick();
    if_req = 0; ram_ready = 1;
    tick();
    ram_ready = 0; ram_rvalid = 1; ram_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    ram_rvalid = 0;
    #1; check("mr_valid", if_valid, 1'b1); check("mr_rdata", if_rdata, 32'hCCCC_DDDD);
    tick();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst        = ($urandom_range(0, 149) != 0);
      if_req     = ($urandom_range(0, 3) != 0);
      mem_req    = ($urandom_range(0, 3) != 0);
      mem_we     = $urandom_range(0, 1);
      if_addr    = {$urandom(), $urandom()};
      mem_addr   = {$urandom(), $urandom()};
      mem_wdata  = {$urandom(), $urandom()};
      mem_wmask  = {$urandom(), $urandom()};
      ram_ready  = $urandom_range(0, 1);
      ram_rvalid = ($urandom_range(0, 2) == 0);
      ram_rdata  = {$urandom(), $urandom()};
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
